// File: rtl/kb_event_ctrl_pkg.sv
// kb_pkg: shared types and sizing helpers for the keyboard event controller
package kb_pkg;
    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, REPEAT} state_t;
    localparam int KB_CODE_W = 8;
    localparam int REP_BIT = KB_CODE_W;
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > 2 ? $clog2(m) : 1;
    endfunction
    localparam int CNT_W = cnt_width(3000, 50_000_000, 10_000_000);
endpackage

// File: rtl/kb_event_ctrl_if.sv
// kb_event_ctrl_if: processor-side event read bus
interface kb_event_ctrl_if #(
    parameter int CODE_W = 8,
    parameter int DEPTH  = 8
);
    logic                   DoRead;
    logic                   int_en;
    logic                   ovf_clr;
    logic [CODE_W:0]        rd_data;
    logic                   empty;
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   interrupt;
    modport master (output DoRead, int_en, ovf_clr, input rd_data, empty, full, count, overflow, interrupt);
    modport slave  (input DoRead, int_en, ovf_clr, output rd_data, empty, full, count, overflow, interrupt);
endinterface

// File: rtl/kb_event_ctrl_fifo.sv
// kb_event_fifo: first-word-fall-through event FIFO with drop indication
module kb_event_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot the push needs
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign dout    = empty ? '0 : mem[rptr];
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/kb_event_ctrl.sv
// kb_event_ctrl: debounces a held key code and emits first-press and auto-repeat events
module kb_event_ctrl
    import kb_pkg::*;
#(
    parameter int CODE_W        = 8,
    parameter int DEPTH         = 8,
    parameter int HOLD_CYCLES   = 3000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [CODE_W-1:0] key_code,
    input  logic              repeat_en,
    kb_event_ctrl_if.slave    bus
);
    localparam int CW = cnt_width(HOLD_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] H1  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] D1  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] P1  = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    state_t            state, state_nx;
    logic [CODE_W-1:0] cur_code, code_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              push, rep, drop;
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            cur_code      <= '0;
            cnt           <= '0;
            bus.overflow  <= 1'b0;
            bus.interrupt <= 1'b0;
        end else begin
            state         <= state_nx;
            cur_code      <= code_nx;
            cnt           <= cnt_nx;
            bus.overflow  <= drop | (bus.overflow & ~bus.ovf_clr);
            bus.interrupt <= bus.int_en & ~bus.empty;
        end
    end
    always_comb begin
        state_nx = state;
        code_nx  = cur_code;
        cnt_nx   = cnt;
        push     = 1'b0;
        rep      = 1'b0;
        case (state)
            IDLE: begin
                if (key_code != '0) begin
                    state_nx = DEBOUNCE;
                    code_nx  = key_code;
                    cnt_nx   = ONE;
                end
            end
            DEBOUNCE: begin
                if (key_code == '0) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (key_code != cur_code) begin
                    code_nx = key_code;
                    cnt_nx  = ONE;
                end else if (cnt >= H1) begin
                    push     = 1'b1;
                    cnt_nx   = '0;
                    state_nx = HELD;
                end else cnt_nx = cnt + 1'b1;
            end
            default: begin
                if (key_code == '0) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (key_code != cur_code) begin
                    state_nx = DEBOUNCE;
                    code_nx  = key_code;
                    cnt_nx   = ONE;
                end else if (!repeat_en) begin
                    // leaving REPEAT keeps cnt; HELD saturates at the delay limit
                    state_nx = HELD;
                    cnt_nx   = (state == REPEAT || cnt >= D1) ? cnt : cnt + 1'b1;
                end else if (cnt >= (state == REPEAT ? P1 : D1)) begin
                    push     = 1'b1;
                    rep      = 1'b1;
                    cnt_nx   = '0;
                    state_nx = REPEAT;
                end else cnt_nx = cnt + 1'b1;
            end
        endcase
    end
    kb_event_fifo #(.W(CODE_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .Reset (Reset),
        .push  (push),
        .pop   (bus.DoRead),
        .din   ({rep, cur_code}),
        .dout  (bus.rd_data),
        .full  (bus.full),
        .empty (bus.empty),
        .count (bus.count),
        .drop  (drop)
    );
endmodule
